rx_frame_fifo: RTL and testbench
================================

// Module: rx_frame_fifo
// PURPOSE
//  Store-and-forward receive FIFO directly downstream of the Rx MAC AXIS master.
//  Buffers each frame, commits it only when TLAST arrives with TUSER=1 (CRC good), and
//  discards it otherwise.
//  Normalises MAC output: folds zero-TKEEP last beats into the previous beat and
//  adds TREADY backpressure.
//  Emits only complete good frames to the user AXIS slave.
// PARAMETERS
//  DATA_WIDTH   32 (localparam)  data width; DATA_NBYTES = DATA_WIDTH/8
//  DEPTH        512              FIFO entries (beats); must be a power of 2, >= 8
//  ADDR_WIDTH   $clog2(DEPTH) (localparam); all pointers are ADDR_WIDTH+1 bits
// PORTS
//  i_clk            in   1   single clock for all logic
//  i_reset          in   1   synchronous, active-high reset
//  s00_axis_tdata   in   32  from Rx MAC; no tready, every valid beat must be taken
//  s00_axis_tkeep   in   4   contiguous from bit 0; may be 0 only when tlast=1
//  s00_axis_tvalid  in   1
//  s00_axis_tlast   in   1
//  s00_axis_tuser   in   1   sampled with tlast only: 1 = CRC good
//  m00_axis_tdata   out  32
//  m00_axis_tkeep   out  4   never 0 while tvalid
//  m00_axis_tvalid  out  1
//  m00_axis_tready  in   1
//  m00_axis_tlast   out  1
//  o_drop           out  1   one-cycle pulse when a frame is discarded (bad CRC or overflow)
//  o_good_cnt, o_crc_drop_cnt, o_ovf_drop_cnt  out  32 each  stats (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all pointers = 0, pending reg empty, all flags 0;
//   m00_axis_tvalid/tlast/tkeep/tdata = 0, o_drop = 0, counters = 0.
//   Reset mid-frame discards the partial frame and every uncommitted frame; no output glitch.
//  Pending reg (1 beat: data, keep, last, good, ovf). At most one RAM write per cycle:
//   - valid beat, keep!=0, !tlast: write pending (if occupied), load beat into pending
//   - valid beat, keep!=0, tlast: write pending (if occupied), load beat with last=1,
//     good=tuser
//   - valid beat, keep==0, tlast: set pending.last=1, good=tuser; no write.
//     If pending is empty, drop frame.
//   - pending.last=1: flush pending to RAM next cycle; a new input beat in that cycle
//     is loaded into pending.
//  Write pointer wr_ptr advances per write; commit_ptr marks the end of committed frames.
//  Full: (wr_ptr - rd_ptr) == DEPTH. A write while full sets frame ovf; all further beats
//   of that frame are discarded and wr_ptr is frozen.
//  Flush (last beat): if good && !ovf, commit_ptr <= wr_ptr+1 next cycle.
//   Otherwise wr_ptr <= commit_ptr, o_drop=1 for that cycle, and the frame is discarded.
//   A frame longer than DEPTH beats is always dropped.
//  Read: data is available when rd_ptr != commit_ptr. Registered RAM read feeds the output
//   reg with a 1-beat skid. Sustains 1 beat/cycle while tready=1.
//   Output holds stable while tvalid && !tready.
//  Latency: tlast accepted at cycle T, flush at T+1, commit at T+2. With output empty,
//   m00_axis_tvalid rises exactly at T+3.
//  Uncommitted beats are never visible on m00. Frame order is preserved.
//   Output tuser is not provided; all output frames are good.
//  Pointer wrap: modulo 2^(ADDR_WIDTH+1); the MSB distinguishes full from empty.
// CONFIGURATION
//  RX_FIFO_STATS_EN defined: 32-bit wrapping counters.
//   o_good_cnt increments at each commit. o_crc_drop_cnt increments at each bad-CRC drop.
//   o_ovf_drop_cnt increments at each overflow drop; ovf takes priority when both apply.
//  Undefined: counter logic not built; the three stat ports are tied to 0 (port list fixed).
// STRUCTURE
//  code_defs_pkg: rx_fifo_beat_t packed struct {data, keep, last} (RAM word, 37 bits).
//  Sub-module sdp_ram (simple dual-port, 1 write/1 read port, registered read,
//   WIDTH/DEPTH params), shared with the Tx path.
// TESTING
//  1 Good frame: keep F,F,F,F,3, tuser=1 on last -> identical 5 beats out, tlast on beat 5;
//    tvalid exactly 3 cycles after input tlast.
//  2 Bad CRC: same frame with tuser=0 -> no output, o_drop pulses once;
//    a following good frame is output intact.
//  3 Zero-keep last: F,F,F then tlast keep=0 tuser=1 -> 3 beats out, beat 3 tlast=1 keep=F.
//  4 Overflow, DEPTH=16: 20-beat good frame -> dropped, o_drop=1, ovf cnt=1;
//    then a 4-beat frame passes.
//  5 Backpressure: 2 back-to-back frames, tready random 50% -> all beats in order;
//    output stable while stalled.
//  6 Reset asserted mid-frame, then good frame -> outputs 0 during reset;
//    only the new frame is output.

Source files
------------

// File: rtl/code_defs_pkg.sv
// Shared type definitions for the Rx frame path: the RAM word carried per beat.
// No logic, no latency.
// Not applicable: types only, no flow control.
package code_defs_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int DATA_NBYTES = DATA_WIDTH / 8;

  // One stored beat: payload, byte enables and end-of-frame marker (37 bits).
  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [DATA_NBYTES-1:0] keep;
    logic                   last;
  } rx_fifo_beat_t;

  localparam int RX_FIFO_BEAT_W = $bits(rx_fifo_beat_t);

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
// Latency: read data valid the cycle after rd_en; rd_dat holds while rd_en is low.
// No backpressure: caller guarantees the read and write addresses never collide.
module sdp_ram #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 512
) (
  input  logic                     i_clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write and registered read; the read register keeps its value when idle.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward Rx FIFO: commits CRC-good frames, drops bad/overflowed ones (stats: RX_FIFO_STATS_EN).
// Latency: input tlast at T -> flush T+1 -> commit T+2 -> m00 tvalid at T+3 (output idle).
// Backpressure: none toward the MAC; m00 holds its beat stable while tvalid && !tready.
module rx_frame_fifo
  import code_defs_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] s00_axis_tdata,
  input  logic [3:0]  s00_axis_tkeep,
  input  logic        s00_axis_tvalid,
  input  logic        s00_axis_tlast,
  input  logic        s00_axis_tuser,
  output logic [31:0] m00_axis_tdata,
  output logic [3:0]  m00_axis_tkeep,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic        m00_axis_tlast,
  output logic        o_drop,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_crc_drop_cnt,
  output logic [31:0] o_ovf_drop_cnt
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_nxt, commit_ptr_nxt;
  rx_fifo_beat_t       pend_beat, pend_beat_nxt, rd_beat;
  logic pend_vld, pend_vld_nxt, pend_good, pend_good_nxt;
  logic frame_ovf, frame_ovf_nxt;
  logic wr_en, full, write_blocked, flush, commit_ok, empty_drop, drop_nxt;
  logic rd_en, out_vld;

  // Full counts uncommitted beats too, so a frame can never overrun unread data.
  assign full          = (wr_ptr - rd_ptr) == FULL_LVL;
  assign write_blocked = frame_ovf || full;
  assign flush         = pend_vld && pend_beat.last;
  assign commit_ok     = pend_good && !write_blocked;
  assign drop_nxt      = (flush && !commit_ok) || empty_drop;

  // Pending-beat staging: decides the single RAM write, commit or rewind for this cycle.
  always_comb begin
    wr_en          = 1'b0;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    pend_vld_nxt   = pend_vld;
    pend_beat_nxt  = pend_beat;
    pend_good_nxt  = pend_good;
    frame_ovf_nxt  = frame_ovf;
    empty_drop     = 1'b0;
    if (flush) begin
      pend_vld_nxt  = 1'b0;
      frame_ovf_nxt = 1'b0;
      if (commit_ok) begin
        wr_en          = 1'b1;
        wr_ptr_nxt     = wr_ptr + PTR_ONE;
        commit_ptr_nxt = wr_ptr + PTR_ONE;
      end else begin
        wr_ptr_nxt = commit_ptr;
      end
    end
    if (s00_axis_tvalid) begin
      if (s00_axis_tkeep != '0) begin
        if (pend_vld && !pend_beat.last) begin
          if (write_blocked) begin
            frame_ovf_nxt = 1'b1;
          end else begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
          end
        end
        pend_vld_nxt       = 1'b1;
        pend_beat_nxt.data = s00_axis_tdata;
        pend_beat_nxt.keep = s00_axis_tkeep;
        pend_beat_nxt.last = s00_axis_tlast;
        pend_good_nxt      = s00_axis_tlast & s00_axis_tuser;
      end else if (s00_axis_tlast) begin
        // Empty trailing beat: mark the held beat as the end of frame.
        if (pend_vld && !pend_beat.last) begin
          pend_beat_nxt.last = 1'b1;
          pend_good_nxt      = s00_axis_tuser;
        end else begin
          empty_drop = 1'b1;
        end
      end
    end
  end

  // Write-side state; reset discards the partial frame and anything uncommitted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pend_vld   <= 1'b0;
      pend_beat  <= '0;
      pend_good  <= 1'b0;
      frame_ovf  <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      pend_vld   <= pend_vld_nxt;
      pend_beat  <= pend_beat_nxt;
      pend_good  <= pend_good_nxt;
      frame_ovf  <= frame_ovf_nxt;
      o_drop     <= drop_nxt;
    end
  end

  sdp_ram #(
    .WIDTH (RX_FIFO_BEAT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_dat  (pend_beat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_dat  (rd_beat)
  );

  // The RAM read register is the output stage; refill it whenever it is empty or being taken.
  assign rd_en = (rd_ptr != commit_ptr) && (!out_vld || m00_axis_tready);

  // Read pointer and output-valid tracking.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr  <= '0;
      out_vld <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (rd_en)                out_vld <= 1'b1;
      else if (m00_axis_tready) out_vld <= 1'b0;
    end
  end

  // Outputs are forced to zero when no beat is held (covers reset and idle).
  assign m00_axis_tvalid = out_vld;
  assign m00_axis_tdata  = out_vld ? rd_beat.data : '0;
  assign m00_axis_tkeep  = out_vld ? rd_beat.keep : '0;
  assign m00_axis_tlast  = out_vld & rd_beat.last;

`ifdef RX_FIFO_STATS_EN
  logic [31:0] good_cnt, crc_cnt, ovf_cnt;
  logic good_inc, crc_inc, ovf_inc;

  // Overflow takes priority over bad CRC when classifying a dropped frame.
  assign good_inc = flush && commit_ok;
  assign ovf_inc  = flush && !commit_ok && write_blocked;
  assign crc_inc  = (flush && !commit_ok && !write_blocked) || empty_drop;

  // Wrapping frame statistics.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      good_cnt <= '0;
      crc_cnt  <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (good_inc) good_cnt <= good_cnt + 32'd1;
      if (crc_inc)  crc_cnt  <= crc_cnt + 32'd1;
      if (ovf_inc)  ovf_cnt  <= ovf_cnt + 32'd1;
    end
  end

  assign o_good_cnt     = good_cnt;
  assign o_crc_drop_cnt = crc_cnt;
  assign o_ovf_drop_cnt = ovf_cnt;
`else
  assign o_good_cnt     = '0;
  assign o_crc_drop_cnt = '0;
  assign o_ovf_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed bench for rx_frame_fifo with a frame-level queue model and per-cycle output compare.
// Latency of the first good frame and drop/stat counts are pinned with literal expectations.
// Output tready is either held high or randomised to exercise stalls.
module tb_rx_frame_fifo;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_dat;
  logic [3:0]  s_keep;
  logic        s_vld, s_last, s_user;
  logic [31:0] m_dat;
  logic [3:0]  m_keep;
  logic        m_vld, m_last, drop;
  logic        m_rdy = 1'b1;
  logic [31:0] good_cnt, crc_cnt, ovf_cnt;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    out_beats = 0;
  int    drops = 0;
  int    last_cyc = 0;
  bit    rdy_rand = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_out;
  beat_t exp_beat;
  logic [3:0] last_keep_out = 4'h0;
  beat_t exp_q[$];

  rx_frame_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .s00_axis_tdata  (s_dat),
    .s00_axis_tkeep  (s_keep),
    .s00_axis_tvalid (s_vld),
    .s00_axis_tlast  (s_last),
    .s00_axis_tuser  (s_user),
    .m00_axis_tdata  (m_dat),
    .m00_axis_tkeep  (m_keep),
    .m00_axis_tvalid (m_vld),
    .m00_axis_tready (m_rdy),
    .m00_axis_tlast  (m_last),
    .o_drop          (drop),
    .o_good_cnt      (good_cnt),
    .o_crc_drop_cnt  (crc_cnt),
    .o_ovf_drop_cnt  (ovf_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    m_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle output check against the queue of committed beats.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", m_vld, 1);
        check("hold_dat", m_dat, prev_out.d);
        check("hold_keep", m_keep, prev_out.k);
        check("hold_last", m_last, prev_out.l);
      end
      if (m_vld && m_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got data %h, expected no beat", m_dat);
        end else begin
          exp_beat = exp_q.pop_front();
          check("out_dat", m_dat, exp_beat.d);
          check("out_keep", m_keep, exp_beat.k);
          check("out_last", m_last, exp_beat.l);
          out_beats++;
          if (m_last) last_keep_out = m_keep;
        end
      end
      prev_stall = m_vld && !m_rdy;
      prev_out   = {m_dat, m_keep, m_last};
    end
  end

  always @(negedge clk) if (drop) drops++;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_vld = 1'b0; s_last = 1'b0; s_user = 1'b0; s_keep = 4'h0; s_dat = '0;
    end
  endtask

  // Drives one frame (all keep F except the last) and records what must come out.
  task automatic send_frame(input logic [7:0] id, input int n, input logic [3:0] lkeep,
                            input logic user);
    beat_t       fr[$];
    logic [3:0]  k;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      k = (i == n - 1) ? lkeep : 4'hF;
      d = {id, 8'h5A, 16'(i)};
      @(posedge clk); #1;
      s_vld = 1'b1; s_dat = d; s_keep = k;
      s_last = (i == n - 1);
      s_user = (i == n - 1) ? user : 1'b0;
      if (i == n - 1) last_cyc = cyc;
      if (k != 4'h0) fr.push_back({d, k, s_last});
      else if (fr.size() > 0) fr[fr.size() - 1].l = 1'b1;
    end
    if (user && fr.size() > 0 && fr.size() <= DEPTH)
      foreach (fr[j]) exp_q.push_back(fr[j]);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_vld"}, m_vld, 0);
    check({tag, "_dat"}, m_dat, 0);
    check({tag, "_keep"}, m_keep, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_drop"}, drop, 0);
  endtask

  task automatic check_stats(input string tag, input int g, input int c, input int o);
`ifdef RX_FIFO_STATS_EN
    check({tag, "_good"}, good_cnt, g);
    check({tag, "_crc"}, crc_cnt, c);
    check({tag, "_ovf"}, ovf_cnt, o);
`else
    check({tag, "_good"}, good_cnt, 0 * g);
    check({tag, "_crc"}, crc_cnt, 0 * c);
    check({tag, "_ovf"}, ovf_cnt, 0 * o);
`endif
  endtask

  int b0, d0, lat;

  initial begin
    rst = 1'b1; s_vld = 1'b0; s_last = 1'b0; s_user = 1'b0; s_keep = 4'h0; s_dat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check_stats("reset", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: good frame, pass-through and latency
    b0 = out_beats;
    send_frame(8'h01, 5, 4'h3, 1'b1);
    idle(1);
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_vld) begin
        lat = cyc - last_cyc;
        break;
      end
    end
    check("t1_latency", lat, 3);
    wait_drain();
    check("t1_beats", out_beats - b0, 5);
    check("t1_last_keep", last_keep_out, 4'h3);

    // 2: bad CRC dropped, next good frame intact
    b0 = out_beats; d0 = drops;
    send_frame(8'h02, 5, 4'h3, 1'b0);
    idle(1);
    send_frame(8'h03, 5, 4'hF, 1'b1);
    idle(1);
    wait_drain();
    check("t2_drops", drops - d0, 1);
    check("t2_beats", out_beats - b0, 5);

    // 3: zero-keep last beat folds into the previous beat
    b0 = out_beats;
    send_frame(8'h04, 4, 4'h0, 1'b1);
    idle(1);
    wait_drain();
    check("t3_beats", out_beats - b0, 3);
    check("t3_last_keep", last_keep_out, 4'hF);

    // 4: frame longer than the FIFO is dropped, a short one still passes
    b0 = out_beats; d0 = drops;
    send_frame(8'h05, 20, 4'hF, 1'b1);
    idle(4);
    check("t4_drops", drops - d0, 1);
    send_frame(8'h06, 4, 4'hF, 1'b1);
    idle(1);
    wait_drain();
    check("t4_beats", out_beats - b0, 4);
    check_stats("t4", 4, 1, 1);

    // 5: back-to-back frames under random backpressure
    b0 = out_beats;
    rdy_rand = 1'b1;
    send_frame(8'h07, 6, 4'h7, 1'b1);
    send_frame(8'h08, 5, 4'h1, 1'b1);
    idle(1);
    wait_drain();
    check("t5_beats", out_beats - b0, 11);
    check("t5_last_keep", last_keep_out, 4'h1);
    rdy_rand = 1'b0;
    idle(4);

    // 6: reset in the middle of a frame, then a fresh frame
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      s_vld = 1'b1; s_dat = {8'hEE, 24'(i)}; s_keep = 4'hF; s_last = 1'b0; s_user = 1'b0;
    end
    @(posedge clk); #1;
    s_vld = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_quiet("t6_rst");
    check_stats("t6_rst", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    b0 = out_beats;
    send_frame(8'h09, 3, 4'hF, 1'b1);
    idle(1);
    wait_drain();
    idle(10);
    check("t6_beats", out_beats - b0, 3);
    check_stats("t6", 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
